// File: rtl/etherneco_rmii_tx.sv
// RMII transmit serializer: sends framed bytes as LSB-first dibits with tx_en,
// enforces an inter-frame gap, truncates frames on underrun and counts outcomes.
module etherneco_rmii_tx #(
  parameter int IFG_CYCLES = 48,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_first,
  input  logic                 s_last,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [1:0]           rmii_txd,
  output logic                 rmii_tx_en,
  output logic                 busy,
  output logic                 underrun,
  output logic                 drop,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] underrun_count
);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam logic [IFG_W-1:0]     IFG_LOAD = IFG_W'(IFG_CYCLES);
  localparam logic [IFG_W-1:0]     IFG_ONE  = IFG_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_IFG     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           sr_q, sr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 cur_last_q, cur_last_d;
  logic [IFG_W-1:0]     ifg_q, ifg_d;
  logic [1:0]           txd_q, txd_d;
  logic                 tx_en_q, tx_en_d;
  logic                 underrun_q, underrun_d;
  logic                 drop_q, drop_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] ur_cnt_q, ur_cnt_d;
  logic                 handshake;

  // Ready depends only on state, dibit index, last flag and reset.
  always_comb begin
    s_ready = 1'b0;
    if (rst) begin
      s_ready = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:    s_ready = 1'b1;
        ST_DATA:    s_ready = (cnt_q == 2'd3) && !cur_last_q;
        ST_DISCARD: s_ready = 1'b1;
        ST_IFG:     s_ready = 1'b0;
        default:    s_ready = 1'b0;
      endcase
    end
  end

  assign handshake = s_valid && s_ready;

  // Next-state logic. The first dibit of a byte is driven straight from s_data
  // at the accepting edge, so sr only keeps the dibits still to be sent.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    cur_last_d  = cur_last_q;
    ifg_d       = ifg_q;
    txd_d       = 2'b00;
    tx_en_d     = 1'b0;
    underrun_d  = 1'b0;
    drop_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    ur_cnt_d    = ur_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake && s_first) begin
          sr_d       = {2'b00, s_data[7:2]};
          txd_d      = s_data[1:0];
          tx_en_d    = 1'b1;
          cnt_d      = 2'd0;
          cur_last_d = s_last;
          state_d    = ST_DATA;
        end else if (handshake) begin
          drop_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != 2'd3) begin
          txd_d   = sr_q[1:0];
          tx_en_d = 1'b1;
          sr_d    = sr_q >> 2;
          cnt_d   = cnt_q + 2'd1;
        end else if (cur_last_q) begin
          frame_cnt_d = frame_cnt_q + CNT_ONE;
          ifg_d       = IFG_LOAD;
          state_d     = ST_IFG;
        end else if (handshake) begin
          sr_d       = {2'b00, s_data[7:2]};
          txd_d      = s_data[1:0];
          tx_en_d    = 1'b1;
          cnt_d      = 2'd0;
          cur_last_d = s_last;
        end else begin
          underrun_d = 1'b1;
          ur_cnt_d   = ur_cnt_q + CNT_ONE;
          state_d    = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (handshake && s_last) begin
          ifg_d   = IFG_LOAD;
          state_d = ST_IFG;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      ST_IFG: begin
        if (ifg_q <= IFG_ONE) begin
          state_d = ST_IDLE;
        end else begin
          ifg_d = ifg_q - IFG_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= 8'h00;
      cnt_q       <= 2'd0;
      cur_last_q  <= 1'b0;
      ifg_q       <= '0;
      txd_q       <= 2'b00;
      tx_en_q     <= 1'b0;
      underrun_q  <= 1'b0;
      drop_q      <= 1'b0;
      frame_cnt_q <= '0;
      ur_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      cur_last_q  <= cur_last_d;
      ifg_q       <= ifg_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      underrun_q  <= underrun_d;
      drop_q      <= drop_d;
      frame_cnt_q <= frame_cnt_d;
      ur_cnt_q    <= ur_cnt_d;
    end
  end

  assign rmii_txd       = txd_q;
  assign rmii_tx_en     = tx_en_q;
  assign busy           = (state_q != ST_IDLE);
  assign underrun       = underrun_q;
  assign drop           = drop_q;
  assign frame_count    = frame_cnt_q;
  assign underrun_count = ur_cnt_q;

endmodule

// File: tb/tb_etherneco_rmii_tx.sv
// Bench for etherneco_rmii_tx: random frame bytes, expected wire timing and
// dibits derived from byte values and the accept/gap timing rules.
module tb_etherneco_rmii_tx;
  localparam int IFG_A = 48;
  localparam int IFG_B = 1;
  localparam int LOGN  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_first = 1'b0, a_last = 1'b0, a_valid = 1'b0;
  logic [7:0]  a_data = 8'h00;
  logic        a_ready, a_en, a_busy, a_ur, a_drop;
  logic [1:0]  a_txd;
  logic [15:0] a_fcnt, a_ucnt;
  logic        b_first = 1'b0, b_last = 1'b0, b_valid = 1'b0;
  logic [7:0]  b_data = 8'h00;
  logic        b_ready, b_en, b_busy, b_ur, b_drop;
  logic [1:0]  b_txd;
  logic [1:0]  b_fcnt, b_ucnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       log_en    [2][LOGN];
  logic [1:0] log_txd   [2][LOGN];
  logic       log_ready [2][LOGN];
  logic       log_busy  [2][LOGN];
  logic       log_ur    [2][LOGN];
  logic       log_drop  [2][LOGN];

  logic [7:0] byte_q [64];
  logic       last_q [64];
  int         acc_q  [64];
  int         lit    [12] = '{1, 1, 1, 1, 1, 1, 1, 3, 3, 0, 2, 2};

  etherneco_rmii_tx #(.IFG_CYCLES(IFG_A), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .s_first(a_first), .s_last(a_last), .s_data(a_data),
    .s_valid(a_valid), .s_ready(a_ready), .rmii_txd(a_txd), .rmii_tx_en(a_en),
    .busy(a_busy), .underrun(a_ur), .drop(a_drop),
    .frame_count(a_fcnt), .underrun_count(a_ucnt));

  etherneco_rmii_tx #(.IFG_CYCLES(IFG_B), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .s_first(b_first), .s_last(b_last), .s_data(b_data),
    .s_valid(b_valid), .s_ready(b_ready), .rmii_txd(b_txd), .rmii_tx_en(b_en),
    .busy(b_busy), .underrun(b_ur), .drop(b_drop),
    .frame_count(b_fcnt), .underrun_count(b_ucnt));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle snapshot of both DUTs, indexed by cycle number.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_en[0][cyc]    <= a_en;    log_en[1][cyc]    <= b_en;
      log_txd[0][cyc]   <= a_txd;   log_txd[1][cyc]   <= b_txd;
      log_ready[0][cyc] <= a_ready; log_ready[1][cyc] <= b_ready;
      log_busy[0][cyc]  <= a_busy;  log_busy[1][cyc]  <= b_busy;
      log_ur[0][cyc]    <= a_ur;    log_ur[1][cyc]    <= b_ur;
      log_drop[0][cyc]  <= a_drop;  log_drop[1][cyc]  <= b_drop;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic f, input logic l,
                       input logic [7:0] d);
    if (sel == 0) begin
      a_valid = v; a_first = f; a_last = l; a_data = d;
    end else begin
      b_valid = v; b_first = f; b_last = l; b_data = d;
    end
  endtask

  // Offers one byte until accepted; returns the cycle of the accepting edge.
  task automatic present(input int sel, input logic f, input logic l,
                         input logic [7:0] d, output int acc);
    int   waited;
    logic rdy;
    drive(sel, 1'b1, f, l, d);
    acc = -1;
    waited = 0;
    while (acc < 0 && waited < 400) begin
      @(negedge clk);
      rdy = (sel == 0) ? a_ready : b_ready;
      if (rdy === 1'b1) acc = cyc;
      @(posedge clk);
      #1;
      waited++;
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
    check("handshake_done", 32'(acc >= 0), 32'd1);
  endtask

  task automatic run_stream(input int sel, input int nb);
    int   acc;
    logic f;
    for (int i = 0; i < nb; i++) begin
      f = 1'b1;
      if (i > 0) f = last_q[i-1];
      present(sel, f, last_q[i], byte_q[i], acc);
      acc_q[i] = acc;
    end
  endtask

  // Each byte: dibits on the four cycles after acceptance. Each frame end:
  // ifg quiet cycles, then ready returns. Next accept follows those rules.
  task automatic verify_stream(input int sel, input int nb, input int ifg);
    int         bad, c, u;
    logic [7:0] sh;
    for (int i = 0; i < nb; i++) begin
      if (i > 0)
        check("accept_cycle", 32'(acc_q[i]),
              32'(last_q[i-1] ? acc_q[i-1] + 5 + ifg : acc_q[i-1] + 4));
      bad = 0;
      for (int k = 0; k < 4; k++) begin
        c = acc_q[i] + 1 + k;
        sh = byte_q[i] >> (2 * k);
        if (log_en[sel][c] !== 1'b1 || log_txd[sel][c] !== sh[1:0]) bad++;
      end
      check("byte_dibits", 32'(bad), 32'd0);
      if (last_q[i]) begin
        u = acc_q[i] + 4;
        bad = 0;
        for (int g = 1; g <= ifg; g++) begin
          if (log_en[sel][u+g] !== 1'b0 || log_txd[sel][u+g] !== 2'b00 ||
              log_ready[sel][u+g] !== 1'b0 || log_busy[sel][u+g] !== 1'b1) bad++;
        end
        check("ifg_quiet", 32'(bad), 32'd0);
        check("ifg_release_ready", 32'(log_ready[sel][u+ifg+1]), 32'd1);
        check("ifg_release_en", 32'(log_en[sel][u+ifg+1]), 32'd0);
        check("ifg_release_busy", 32'(log_busy[sel][u+ifg+1]), 32'd0);
      end
    end
  endtask

  initial begin
    int a0, a1, c0, c1, c2, c3, nb, sum, bad, u, len;
    logic [7:0] sh;

    // reset state, with ready forced low while rst is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_a", 32'(a_ready), 32'd0);
    check("rst_ready_b", 32'(b_ready), 32'd0);
    check("rst_tx_en", 32'(a_en), 32'd0);
    check("rst_txd", 32'(a_txd), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_fcnt", 32'(a_fcnt), 32'd0);
    check("rst_ucnt", 32'(a_ucnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready_a", 32'(a_ready), 32'd1);
    check("idle_ready_b", 32'(b_ready), 32'd1);
    check("idle_underrun", 32'(a_ur), 32'd0);
    check("idle_drop", 32'(a_drop), 32'd0);
    @(posedge clk); #1;

    // fixed three-byte frame
    byte_q[0] = 8'h55; last_q[0] = 1'b0;
    byte_q[1] = 8'hD5; last_q[1] = 1'b0;
    byte_q[2] = 8'hA3; last_q[2] = 1'b1;
    run_stream(0, 3);
    repeat (IFG_A + 8) @(posedge clk);
    #1;
    verify_stream(0, 3, IFG_A);
    for (int k = 0; k < 12; k++)
      check("s1_txd_seq", 32'(log_txd[0][acc_q[0]+1+k]), 32'(lit[k]));
    check("s1_frame_count", 32'(a_fcnt), 32'd1);

    // five queued random frames; first two are two bytes long
    nb = 0;
    for (int f = 0; f < 5; f++) begin
      len = (f < 2) ? 2 : int'($urandom_range(4, 1));
      for (int j = 0; j < len; j++) begin
        byte_q[nb] = 8'($urandom);
        last_q[nb] = (j == len - 1);
        nb++;
      end
    end
    run_stream(0, nb);
    repeat (IFG_A + 8) @(posedge clk);
    #1;
    verify_stream(0, nb, IFG_A);
    u = acc_q[1] + 4;
    sum = 0;
    for (int c = u + 1; c <= acc_q[2]; c++) if (log_en[0][c] === 1'b0) sum++;
    check("s2_gap_cycles", 32'(sum), 32'd49);
    check("s2_second_start_en", 32'(log_en[0][acc_q[2]+1]), 32'd1);
    check("s2_frame_count", 32'(a_fcnt), 32'd6);
    check("s2_underrun_count", 32'(a_ucnt), 32'd0);

    // underrun after first byte of a four-byte frame
    for (int j = 0; j < 4; j++) byte_q[j] = 8'($urandom);
    present(0, 1'b1, 1'b0, byte_q[0], a0);
    repeat (8) @(posedge clk);
    #1;
    present(0, 1'b0, 1'b0, byte_q[1], c1);
    present(0, 1'b0, 1'b0, byte_q[2], c2);
    present(0, 1'b0, 1'b1, byte_q[3], c3);
    repeat (IFG_A + 8) @(posedge clk);
    #1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      sh = byte_q[0] >> (2 * k);
      if (log_en[0][a0+1+k] !== 1'b1 || log_txd[0][a0+1+k] !== sh[1:0]) bad++;
    end
    check("ur_dibits", 32'(bad), 32'd0);
    check("ur_en_falls", 32'(log_en[0][a0+5]), 32'd0);
    check("ur_pulse", 32'(log_ur[0][a0+5]), 32'd1);
    sum = 0;
    for (int c = a0; c <= c3 + IFG_A + 2; c++) if (log_ur[0][c] === 1'b1) sum++;
    check("ur_pulse_count", 32'(sum), 32'd1);
    sum = 0;
    for (int c = a0 + 5; c <= c3 + IFG_A; c++) if (log_en[0][c] !== 1'b0) sum++;
    check("ur_no_tx_en", 32'(sum), 32'd0);
    check("ur_discard_accept1", 32'(c1), 32'(a0 + 9));
    check("ur_discard_accept3", 32'(c3), 32'(c1 + 2));
    bad = 0;
    for (int g = 1; g <= IFG_A; g++)
      if (log_ready[0][c3+g] !== 1'b0 || log_busy[0][c3+g] !== 1'b1) bad++;
    check("ur_ifg_quiet", 32'(bad), 32'd0);
    check("ur_ifg_release", 32'(log_ready[0][c3+IFG_A+1]), 32'd1);
    check("ur_underrun_count", 32'(a_ucnt), 32'd1);
    check("ur_frame_count", 32'(a_fcnt), 32'd6);

    // stray byte without s_first in IDLE
    present(0, 1'b0, 1'b0, 8'h12, c0);
    repeat (4) @(posedge clk);
    #1;
    check("stray_drop_pulse", 32'(log_drop[0][c0+1]), 32'd1);
    sum = 0;
    for (int c = c0; c <= c0 + 4; c++) if (log_drop[0][c] === 1'b1) sum++;
    check("stray_drop_count", 32'(sum), 32'd1);
    sum = 0;
    for (int c = c0; c <= c0 + 4; c++)
      if (log_en[0][c] !== 1'b0 || log_busy[0][c] !== 1'b0) sum++;
    check("stray_quiet", 32'(sum), 32'd0);
    check("stray_frame_count", 32'(a_fcnt), 32'd6);

    // reset during the second dibit of the second byte
    byte_q[0] = 8'($urandom);
    byte_q[1] = 8'($urandom);
    present(0, 1'b1, 1'b0, byte_q[0], a0);
    present(0, 1'b0, 1'b0, byte_q[1], a1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_en", 32'(a_en), 32'd0);
    check("mid_rst_txd", 32'(a_txd), 32'd0);
    check("mid_rst_ready", 32'(a_ready), 32'd0);
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(a_ready), 32'd1);
    check("post_rst_fcnt", 32'(a_fcnt), 32'd0);
    check("post_rst_ucnt", 32'(a_ucnt), 32'd0);
    check("mid_rst_accept", 32'(a1), 32'(a0 + 4));
    sh = byte_q[1];
    check("mid_rst_byte2_d0", 32'(log_txd[0][a1+1]), 32'(sh[1:0]));
    repeat (4) @(posedge clk);
    #1;
    sum = 0;
    for (int c = a1; c <= a1 + 8; c++) if (log_ur[0][c] === 1'b1) sum++;
    check("mid_rst_no_underrun", 32'(sum), 32'd0);

    // IFG_CYCLES=1, CNT_WIDTH=2 instance: five frames, count wraps
    nb = 0;
    for (int f = 0; f < 5; f++) begin
      len = (f == 0) ? 1 : int'($urandom_range(2, 1));
      for (int j = 0; j < len; j++) begin
        byte_q[nb] = 8'($urandom);
        last_q[nb] = (j == len - 1);
        nb++;
      end
    end
    c0 = cyc;
    run_stream(1, nb);
    repeat (IFG_B + 8) @(posedge clk);
    #1;
    verify_stream(1, nb, IFG_B);
    check("b_frame_count_wrap", 32'(b_fcnt), 32'd1);
    check("b_underrun_count", 32'(b_ucnt), 32'd0);
    sum = 0;
    for (int c = c0; c < cyc; c++)
      if (log_drop[1][c] === 1'b1 || log_ur[1][c] === 1'b1) sum++;
    check("b_no_drop_underrun", 32'(sum), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
